// File: rtl/sample_processor_p.sv
// sample_processor_p: offset-binary ADC sample -> two's complement -> selectable
// operation (bypass / moving average / saturating gain / attenuate) -> DAC offset.
// Optional feature macro: CLIP_DETECT_EN (adds clip_clr input and sticky clip output).
//
// Ports:
//   sysclk      system clock, all logic on rising edge
//   reset       synchronous active-high reset
//   data_valid  one-cycle strobe, data_in holds a new sample
//   data_in     offset-binary ADC sample
//   mode        00 bypass, 01 moving average, 10 gain, 11 attenuate
//   shift       shift amount for gain/attenuate (0..7)
//   data_out    offset-binary DAC sample, registered
//   out_valid   one-cycle strobe, data_out updated this cycle
//   clip_clr    (CLIP_DETECT_EN) clears sticky clip flag
//   clip        (CLIP_DETECT_EN) sticky flag, set when a gain result saturated
module sample_processor_p #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned ADC_OFFSET = 385,
  parameter int unsigned DAC_OFFSET = 512,
  parameter int unsigned LOG2_TAPS  = 3
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        mode,
  input  logic [2:0]        shift,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid
`ifdef CLIP_DETECT_EN
  ,
  input  logic              clip_clr,
  output logic              clip
`endif
);

  localparam int unsigned TAPS   = 2 ** LOG2_TAPS;
  localparam int unsigned SUM_W  = DATA_W + LOG2_TAPS;
  localparam int unsigned GAIN_W = DATA_W + 7;

  localparam logic signed [GAIN_W-1:0] Y_MAX = GAIN_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [GAIN_W-1:0] Y_MIN = GAIN_W'(-(2 ** (DATA_W - 1)));

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_AVG    = 2'b01;
  localparam logic [1:0] MODE_GAIN   = 2'b10;
  localparam logic [1:0] MODE_ATTEN  = 2'b11;

  // Stage 1 registers: signed sample plus the mode/shift captured with it
  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_x;
  logic [1:0]               s1_mode;
  logic [2:0]               s1_shift;

  // Moving-average history
  logic signed [DATA_W-1:0] hist [TAPS];
  logic [LOG2_TAPS-1:0]     wptr;
  logic signed [SUM_W-1:0]  sum;

  logic signed [SUM_W-1:0]  sum_c;
  logic signed [GAIN_W-1:0] gain_c;
  logic                     sat_c;
  logic signed [DATA_W-1:0] y_c;

  // Stage 0: remove ADC offset (wrapping) and capture control with the sample
  always_ff @(posedge sysclk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_mode  <= '0;
      s1_shift <= '0;
    end else begin
      s1_valid <= data_valid;
      if (data_valid) begin
        s1_x     <= $signed(data_in - DATA_W'(ADC_OFFSET));
        s1_mode  <= mode;
        s1_shift <= shift;
      end
    end
  end

  // Running sum including the current sample; the oldest entry drops out
  always_comb begin
    sum_c = sum + SUM_W'(s1_x) - SUM_W'(hist[wptr]);
  end

  // History updates in every mode so a switch into averaging is immediately valid
  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int i = 0; i < int'(TAPS); i++) hist[i] <= '0;
      wptr <= '0;
      sum  <= '0;
    end else if (s1_valid) begin
      hist[wptr] <= s1_x;
      wptr       <= wptr + LOG2_TAPS'(1);
      sum        <= sum_c;
    end
  end

  // Operation select; gain saturates from the wide intermediate
  always_comb begin
    gain_c = GAIN_W'(s1_x) <<< s1_shift;
    sat_c  = (gain_c > Y_MAX) || (gain_c < Y_MIN);
    y_c    = s1_x;
    case (s1_mode)
      MODE_BYPASS: y_c = s1_x;
      MODE_AVG:    y_c = DATA_W'(sum_c >>> LOG2_TAPS);
      MODE_GAIN: begin
        if (gain_c > Y_MAX)      y_c = DATA_W'(Y_MAX);
        else if (gain_c < Y_MIN) y_c = DATA_W'(Y_MIN);
        else                     y_c = DATA_W'(gain_c);
      end
      MODE_ATTEN:  y_c = s1_x >>> s1_shift;
      default:     y_c = s1_x;
    endcase
  end

  // Stage 2: re-offset for the DAC; data_out holds between samples
  always_ff @(posedge sysclk) begin
    if (reset) begin
      data_out  <= DATA_W'(DAC_OFFSET);
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) data_out <= DATA_W'(y_c) + DATA_W'(DAC_OFFSET);
    end
  end

`ifdef CLIP_DETECT_EN
  // Sticky clip flag; a new saturation wins over a simultaneous clear
  always_ff @(posedge sysclk) begin
    if (reset) begin
      clip <= 1'b0;
    end else if (s1_valid && (s1_mode == MODE_GAIN) && sat_c) begin
      clip <= 1'b1;
    end else if (clip_clr) begin
      clip <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/sample_processor_p.md
Name: sample_processor_p

Overview:
- Parametrised successor to the single-mode all-pass audio processor.
- Converts offset-binary ADC samples to two's complement and applies a runtime-selected operation: bypass, moving average, saturating gain or attenuation.
- Re-offsets the result for the DAC.
- Sits between the ADC interface and the DAC interface on the system clock, gated by a per-sample strobe.

Parameters:
- DATA_W, 10: sample width in bits, for both input and output.
- ADC_OFFSET, 385: offset subtracted from data_in to form signed x.
- DAC_OFFSET, 512: offset added to signed y to form data_out.
- LOG2_TAPS, 3: moving-average depth is 2^LOG2_TAPS samples. Legal range 1..6.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- data_valid  in  1  one-cycle strobe: data_in holds a new sample
- data_in  in  DATA_W  offset-binary ADC sample
- mode  in  2  00 bypass, 01 moving average, 10 gain, 11 attenuate
- shift  in  3  shift amount for gain/attenuate modes, 0..7
- data_out  out  DATA_W  offset-binary DAC sample, registered
- out_valid  out  1  one-cycle strobe: data_out updated this cycle

Behaviour:
- Reset (synchronous, active-high):
  - data_out = DAC_OFFSET (mid-scale silence); out_valid = 0.
  - Pipeline registers, all delay-line entries, write pointer and accumulator cleared to 0.
  - data_valid is ignored while reset = 1.
- Stage 0 (the cycle data_valid = 1):
  - x = data_in - ADC_OFFSET, DATA_W-bit two's complement, wrapping (no saturation).
  - mode and shift are sampled with the sample and travel down the pipeline with it.
- Stage 1 (registered x):
  - Delay line: circular buffer of 2^LOG2_TAPS signed DATA_W entries; the write pointer wraps to 0 after the last entry.
  - Per valid sample: sum <= sum + x - oldest; oldest is overwritten with x; pointer advances.
  - sum is DATA_W+LOG2_TAPS bits signed and never overflows.
  - The delay line updates on every valid sample in every mode, so switching into mode 01 yields a correct average immediately.
- Stage 2 (y computed, output registered):
  - 00: y = x.
  - 01: y = (sum including current x) >>> LOG2_TAPS, arithmetic shift (floor).
  - 10: y = x << shift, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; intermediate width DATA_W+7.
  - 11: y = x >>> shift, arithmetic (floor).
  - data_out <= y + DAC_OFFSET, truncated to DATA_W bits; out_valid <= 1 for one cycle.
- Latency: out_valid pulses exactly 2 cycles after the data_valid that produced it.
- Throughput: data_valid accepted every cycle back-to-back; no backpressure.
- Between samples: data_out holds its last value; out_valid = 0.
- Reset asserted mid-stream: in-flight samples are discarded, no out_valid is produced for them, and the average restarts from an all-zero history.
- mode/shift changes between samples take effect from the next sample; in-flight samples keep their own sampled mode/shift.

Optional Feature:
- CLIP_DETECT_EN defined:
  - Adds input clip_clr (1 bit) and output clip (1 bit).
  - clip is sticky: it sets in the cycle out_valid reports a mode-10 result that saturated.
  - clip clears on reset or clip_clr = 1. If clip_clr and a new saturation coincide, set wins.
- Not defined: neither port exists; saturation behaviour is unchanged.

Test Plan:
- Reset, then data_valid with data_in=385, mode=00 -> x=0, 2 cycles later out_valid=1, data_out=512; with no strobe, data_out stays 512 and out_valid=0.
- Mode 00, data_in=485 -> data_out=612 at +2 cycles. Three back-to-back strobes 485/385/285 -> outputs 612/512/412 on consecutive cycles.
- Mode 10, data_in=485: shift=2 -> 912; shift=3 -> saturates to 511 -> 1023 (clip=1 with CLIP_DETECT_EN). Mode 10, data_in=0 (x=-385), shift=1 -> saturates to -512 -> data_out=0.
- Mode 11, data_in=0, shift=2 -> y=-97 -> data_out=415. Mode 11, data_in=485, shift=7 -> y=0 -> data_out=512.
- After reset, mode 01, eight strobes of data_in=465 (x=80) -> data_out 522,532,...,592. A ninth strobe of 465 -> 592. Then eight strobes of 385 -> ramps back down to 512.
- Mode 01 mid-ramp (four samples of x=80), reset pulse, then one sample x=80 -> data_out=522. No out_valid for the sample in flight during reset.
